// File: rtl/motor_cmd_engine_if.sv
// Byte-stream handshake bundle between the UART RX/TX byte engines and motor_cmd_engine.
// master = UART side, slave = command engine.
interface motor_cmd_engine_if;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       rx_ready;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ready;

    modport master (
        output rx_data, rx_valid, tx_ready,
        input  rx_ready, tx_data, tx_valid
    );

    modport slave (
        input  rx_data, rx_valid, tx_ready,
        output rx_ready, tx_data, tx_valid
    );
endinterface

// File: rtl/motor_cmd_engine.sv
// Assembles UART motor command frames, drives NCH sign/magnitude PWM pairs for D*DUR_TICKS
// cycles, then answers ACK/NAK. Define CHECKSUM_EN to add a trailing XOR checksum byte.
//
// state | meaning
// RECV  | collecting frame bytes; index==FRAME_LEN is the one-cycle commit step
// EXEC  | driving PWM pairs until the duration counter expires
// RESP  | holding ACK/NAK on tx until the TX engine takes it
module motor_cmd_engine #(
    parameter int         NCH         = 2,
    parameter int         PWM_W       = 7,
    parameter int         DUR_TICKS   = 4194304,
    parameter int         TIMEOUT_CYC = 65536,
    parameter logic [7:0] ACK_BYTE    = 8'h41,
    parameter logic [7:0] NAK_BYTE    = 8'h4E
) (
    input  logic              clk,
    input  logic              resetTrigger,
    motor_cmd_engine_if.slave bus,
    output logic [2*NCH-1:0]  ch_out_o,
    output logic              busy_o
);

`ifdef CHECKSUM_EN
    localparam int FRAME_LEN = NCH + 2;
`else
    localparam int FRAME_LEN = NCH + 1;
`endif
    localparam int IDX_W = $clog2(FRAME_LEN + 1);
    localparam int TO_W  = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
    localparam int DUR_W = $clog2(256 * DUR_TICKS);

    typedef enum logic [1:0] {RECV, EXEC, RESP} state_t;

    state_t                          state_q, state_d;
    logic [IDX_W-1:0]                idx_q, idx_d;
    logic [FRAME_LEN-1:0][7:0]       shadow_q, shadow_d;
    logic [NCH-1:0][PWM_W-1:0]       mag_q, mag_d;
    logic [NCH-1:0]                  dir_q, dir_d;
    logic [7:0]                      dur_q, dur_d;
    logic [PWM_W-1:0]                pwm_cnt_q, pwm_cnt_d;
    logic [DUR_W-1:0]                dur_cnt_q, dur_cnt_d;
    logic [TO_W-1:0]                 to_cnt_q, to_cnt_d;
    logic [2*NCH-1:0]                ch_out_q, ch_out_d;
    logic                            tx_valid_q, tx_valid_d;
    logic [7:0]                      tx_data_q, tx_data_d;
    logic                            rx_ready_q, rx_ready_d;
    logic                            accept;
    logic                            frame_ok;
`ifdef CHECKSUM_EN
    logic [7:0]                      csum;
`endif

    // Direction 0 drives the upper leg, direction 1 the lower leg; never both.
    function automatic logic [2*NCH-1:0] drive(
        input logic [NCH-1:0][PWM_W-1:0] mag,
        input logic [NCH-1:0]            dir,
        input logic [PWM_W-1:0]          cnt
    );
        logic [2*NCH-1:0] v;
        logic             pwm;
        v = '0;
        for (int i = 0; i < NCH; i++) begin
            pwm        = (mag[i] > cnt);
            v[2*i+1]   = pwm & ~dir[i];
            v[2*i]     = pwm & dir[i];
        end
        return v;
    endfunction

    always_ff @(posedge clk or posedge resetTrigger) begin
        if (resetTrigger) begin
            state_q    <= RECV;
            idx_q      <= '0;
            shadow_q   <= '0;
            mag_q      <= '0;
            dir_q      <= '0;
            dur_q      <= '0;
            pwm_cnt_q  <= '0;
            dur_cnt_q  <= '0;
            to_cnt_q   <= '0;
            ch_out_q   <= '0;
            tx_valid_q <= 1'b0;
            tx_data_q  <= '0;
            rx_ready_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            shadow_q   <= shadow_d;
            mag_q      <= mag_d;
            dir_q      <= dir_d;
            dur_q      <= dur_d;
            pwm_cnt_q  <= pwm_cnt_d;
            dur_cnt_q  <= dur_cnt_d;
            to_cnt_q   <= to_cnt_d;
            ch_out_q   <= ch_out_d;
            tx_valid_q <= tx_valid_d;
            tx_data_q  <= tx_data_d;
            rx_ready_q <= rx_ready_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        shadow_d   = shadow_q;
        mag_d      = mag_q;
        dir_d      = dir_q;
        dur_d      = dur_q;
        pwm_cnt_d  = pwm_cnt_q;
        dur_cnt_d  = dur_cnt_q;
        to_cnt_d   = to_cnt_q;
        ch_out_d   = '0;
        tx_valid_d = tx_valid_q;
        tx_data_d  = tx_data_q;
        frame_ok   = 1'b1;
        accept     = bus.rx_valid & rx_ready_q;
`ifdef CHECKSUM_EN
        csum       = '0;
`endif

        unique case (state_q)
            RECV: begin
                if (idx_q == IDX_W'(FRAME_LEN)) begin
`ifdef CHECKSUM_EN
                    for (int k = 0; k < FRAME_LEN - 1; k++) begin
                        csum = csum ^ shadow_q[k];
                    end
                    frame_ok = (csum == shadow_q[FRAME_LEN-1]);
`endif
                    idx_d = '0;
                    if (frame_ok) begin
                        for (int i = 0; i < NCH; i++) begin
                            mag_d[i] = shadow_q[i][PWM_W-1:0];
                            dir_d[i] = shadow_q[i][7];
                        end
                        dur_d     = shadow_q[NCH];
                        pwm_cnt_d = '0;
                        // Down-counter: EXEC lasts load+1 cycles, so D=0 still gives one cycle.
                        if (dur_d == 8'd0) begin
                            dur_cnt_d = '0;
                            ch_out_d  = '0;
                        end else begin
                            dur_cnt_d = DUR_W'(dur_d) * DUR_W'(DUR_TICKS) - DUR_W'(1);
                            ch_out_d  = drive(mag_d, dir_d, '0);
                        end
                        state_d = EXEC;
                    end else begin
                        state_d    = RESP;
                        tx_valid_d = 1'b1;
                        tx_data_d  = NAK_BYTE;
                    end
                end else if (accept) begin
                    for (int k = 0; k < FRAME_LEN; k++) begin
                        if (idx_q == IDX_W'(k)) shadow_d[k] = bus.rx_data;
                    end
                    idx_d    = idx_q + IDX_W'(1);
                    to_cnt_d = TO_W'(TIMEOUT_CYC - 1);
                end else if (idx_q != '0) begin
                    if (to_cnt_q == '0) begin
                        idx_d      = '0;
                        state_d    = RESP;
                        tx_valid_d = 1'b1;
                        tx_data_d  = NAK_BYTE;
                    end else begin
                        to_cnt_d = to_cnt_q - TO_W'(1);
                    end
                end
            end
            EXEC: begin
                if (dur_cnt_q == '0) begin
                    state_d    = RESP;
                    tx_valid_d = 1'b1;
                    tx_data_d  = ACK_BYTE;
                end else begin
                    dur_cnt_d = dur_cnt_q - DUR_W'(1);
                    pwm_cnt_d = pwm_cnt_q + PWM_W'(1);
                    ch_out_d  = drive(mag_q, dir_q, pwm_cnt_d);
                end
            end
            RESP: begin
                if (bus.tx_ready) begin
                    tx_valid_d = 1'b0;
                    idx_d      = '0;
                    state_d    = RECV;
                end
            end
            default: state_d = RECV;
        endcase

        rx_ready_d = (state_d == RECV) && (idx_d != IDX_W'(FRAME_LEN));
    end

    assign bus.rx_ready = rx_ready_q;
    assign bus.tx_valid = tx_valid_q;
    assign bus.tx_data  = tx_data_q;
    assign ch_out_o     = ch_out_q;
    assign busy_o       = (state_q == EXEC) || (state_q == RESP);

endmodule

// File: tb/tb_motor_cmd_engine.sv
// Self-checking bench for motor_cmd_engine (NCH=2, PWM_W=7, DUR_TICKS=4, TIMEOUT_CYC=32);
// follows CHECKSUM_EN when it is defined for the build.
module tb_motor_cmd_engine;
    localparam int DUR_TICKS = 4;
`ifdef CHECKSUM_EN
    localparam int FL = 4;
`else
    localparam int FL = 3;
`endif

    logic       clk = 1'b0;
    logic       resetTrigger;
    logic [3:0] ch_out;
    logic       busy;
    logic [7:0] frame [FL];
    int         n_chk = 0;
    int         n_fail = 0;

    motor_cmd_engine_if bus();

    motor_cmd_engine #(
        .NCH(2), .PWM_W(7), .DUR_TICKS(DUR_TICKS), .TIMEOUT_CYC(32),
        .ACK_BYTE(8'h41), .NAK_BYTE(8'h4E)
    ) dut (
        .clk(clk), .resetTrigger(resetTrigger), .bus(bus),
        .ch_out_o(ch_out), .busy_o(busy)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    typedef struct {
        logic [7:0] c0, c1, d;
        logic [7:0] exp_resp;
        int         exp_len;
    } vec_t;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Expected H-bridge legs k cycles into EXEC, straight from the duty rule.
    function automatic logic [3:0] model_ch(input logic [7:0] c0, input logic [7:0] c1, input int k);
        logic [7:0] cb [2];
        logic [3:0] r;
        r = '0;
        cb[0] = c0;
        cb[1] = c1;
        for (int i = 0; i < 2; i++) begin
            if (int'(cb[i] & 8'h7F) > (k % 128)) begin
                if (cb[i][7]) r[2*i] = 1'b1;
                else          r[2*i+1] = 1'b1;
            end
        end
        return r;
    endfunction

    task automatic set_frame(input logic [7:0] c0, input logic [7:0] c1, input logic [7:0] d,
                             input logic [7:0] flip);
        frame[0] = c0;
        frame[1] = c1;
        frame[2] = d;
`ifdef CHECKSUM_EN
        frame[3] = c0 ^ c1 ^ d ^ flip;
`else
        if (flip != 8'h00) frame[2] = d;
`endif
    endtask

    task automatic send_byte(input logic [7:0] b);
        int n;
        n = 0;
        bus.rx_data  = b;
        bus.rx_valid = 1'b1;
        @(negedge clk);
        while (!bus.rx_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (n >= 200) check("rx_ready_wait", 32'(bus.rx_ready), 32'd1);
        @(posedge clk);
        #1;
        bus.rx_valid = 1'b0;
    endtask

    task automatic send_frame(input int gap_max);
        for (int i = 0; i < FL; i++) begin
            send_byte(frame[i]);
            if (i < FL - 1) begin
                repeat ($urandom_range(0, gap_max)) @(posedge clk);
                #1;
            end
        end
    endtask

    // Called just after the last byte's accept edge.
    task automatic run_exec(input logic [7:0] c0, input logic [7:0] c1, input logic [7:0] d,
                            input int len, input logic [7:0] resp);
        @(negedge clk);
        check("commit_cycle", {busy, bus.rx_ready, ch_out}, 6'b000000);
        for (int k = 0; k < len; k++) begin
            @(negedge clk);
            check("exec_flags", {busy, bus.tx_valid, bus.rx_ready}, 3'b100);
            check("exec_ch_out", 32'(ch_out), (d == 8'd0) ? 32'd0 : 32'(model_ch(c0, c1, k)));
        end
        @(negedge clk);
        check("resp_valid", {busy, bus.tx_valid}, 2'b11);
        check("resp_data", 32'(bus.tx_data), 32'(resp));
        check("resp_ch_out", 32'(ch_out), 32'd0);
    endtask

    task automatic run_nak();
        @(negedge clk);
        check("nak_commit_ch", 32'(ch_out), 32'd0);
        @(negedge clk);
        check("nak_valid", {busy, bus.tx_valid}, 2'b11);
        check("nak_data", 32'(bus.tx_data), 32'h4E);
        check("nak_ch_out", 32'(ch_out), 32'd0);
    endtask

    // Entered at a negedge inside RESP.
    task automatic finish_resp();
        bus.tx_ready = 1'b1;
        @(negedge clk);
        check("after_handshake", {bus.tx_valid, busy, bus.rx_ready}, 3'b001);
        @(posedge clk);
        #1;
    endtask

    vec_t vecs [6];

    initial begin
        logic [7:0] c0, c1, d;
        bit         bad;
        int         gap;

        vecs[0] = '{8'h40, 8'hC0, 8'h02, 8'h41, 8};
        vecs[1] = '{8'h7F, 8'h00, 8'h01, 8'h41, 4};
        vecs[2] = '{8'h05, 8'h05, 8'h00, 8'h41, 1};
        vecs[3] = '{8'h00, 8'hFF, 8'h01, 8'h41, 4};
        vecs[4] = '{8'h81, 8'h7F, 8'h03, 8'h41, 12};
        vecs[5] = '{8'hFF, 8'h80, 8'h00, 8'h41, 1};

        resetTrigger = 1'b1;
        bus.rx_valid = 1'b0;
        bus.rx_data  = 8'h00;
        bus.tx_ready = 1'b1;
        repeat (3) @(negedge clk);
        check("reset_outputs", {ch_out, bus.tx_valid, busy}, 6'b0);
        check("reset_tx_data", 32'(bus.tx_data), 32'd0);
        @(posedge clk);
        #1;
        resetTrigger = 1'b0;
        @(posedge clk);
        #1;
        check("rx_ready_after_reset", 32'(bus.rx_ready), 32'd1);

        // Table of well-formed frames, all acknowledged.
        for (int i = 0; i < 6; i++) begin
            set_frame(vecs[i].c0, vecs[i].c1, vecs[i].d, 8'h00);
            send_frame(0);
            run_exec(vecs[i].c0, vecs[i].c1, vecs[i].d, vecs[i].exp_len, vecs[i].exp_resp);
            finish_resp();
        end

        // Inter-byte timeout: NAK exactly 32 cycles after the lone byte.
        send_byte(8'h10);
        gap = 0;
        @(negedge clk);
        while (!bus.tx_valid && gap < 100) begin
            check("timeout_ch_out", 32'(ch_out), 32'd0);
            gap++;
            @(negedge clk);
        end
        check("timeout_gap", 32'(gap), 32'd32);
        check("timeout_nak", 32'(bus.tx_data), 32'h4E);
        finish_resp();
        set_frame(8'h40, 8'hC0, 8'h02, 8'h00);
        send_frame(2);
        run_exec(8'h40, 8'hC0, 8'h02, 8, 8'h41);
        finish_resp();

`ifdef CHECKSUM_EN
        set_frame(8'h7F, 8'h00, 8'h01, 8'h00);
        send_frame(0);
        run_exec(8'h7F, 8'h00, 8'h01, 4, 8'h41);
        finish_resp();
        frame[3] = 8'h7F;
        send_frame(0);
        run_nak();
        finish_resp();
`endif

        // Response held off by tx_ready low.
        bus.tx_ready = 1'b0;
        set_frame(8'h05, 8'h05, 8'h00, 8'h00);
        send_frame(0);
        run_exec(8'h05, 8'h05, 8'h00, 1, 8'h41);
        for (int j = 0; j < 10; j++) begin
            @(negedge clk);
            check("held_resp", {bus.tx_valid, bus.tx_data, busy}, {1'b1, 8'h41, 1'b1});
        end
        finish_resp();

        // Reset during EXEC; rx_valid pulses must be ignored.
        set_frame(8'h40, 8'hC0, 8'h10, 8'h00);
        send_frame(0);
        @(negedge clk);
        for (int j = 0; j < 5; j++) begin
            @(negedge clk);
            check("exec_rx_blocked", 32'(bus.rx_ready), 32'd0);
            check("exec_mid_ch", 32'(ch_out), 32'(model_ch(8'h40, 8'hC0, j)));
            bus.rx_data  = 8'hAA;
            bus.rx_valid = (j % 2 == 0);
        end
        bus.rx_valid = 1'b0;
        @(posedge clk);
        #1;
        resetTrigger = 1'b1;
        #1;
        check("reset_mid_exec", {ch_out, bus.tx_valid, busy}, 6'b0);
        repeat (2) @(posedge clk);
        #1;
        resetTrigger = 1'b0;
        for (int j = 0; j < 10; j++) begin
            @(negedge clk);
            check("no_resp_after_reset", {bus.tx_valid, busy}, 2'b00);
        end
        @(posedge clk);
        #1;
        set_frame(8'h40, 8'hC0, 8'h02, 8'h00);
        send_frame(1);
        run_exec(8'h40, 8'hC0, 8'h02, 8, 8'h41);
        finish_resp();

        // Back-to-back: next frame offered while the ACK is still pending.
        bus.tx_ready = 1'b0;
        set_frame(8'h81, 8'h7F, 8'h01, 8'h00);
        send_frame(0);
        run_exec(8'h81, 8'h7F, 8'h01, 4, 8'h41);
        set_frame(8'h40, 8'hC0, 8'h01, 8'h00);
        bus.rx_data  = frame[0];
        bus.rx_valid = 1'b1;
        for (int j = 0; j < 4; j++) begin
            @(negedge clk);
            check("b2b_blocked", {bus.rx_ready, bus.tx_valid}, 2'b01);
        end
        bus.tx_ready = 1'b1;
        @(negedge clk);
        check("b2b_released", {bus.rx_ready, bus.tx_valid}, 2'b10);
        @(posedge clk);
        #1;
        bus.rx_valid = 1'b0;
        for (int i = 1; i < FL; i++) send_byte(frame[i]);
        run_exec(8'h40, 8'hC0, 8'h01, 4, 8'h41);
        finish_resp();

        // Randomized frames against the duty/duration rules.
        for (int r = 0; r < 20; r++) begin
            c0  = 8'($urandom);
            c1  = 8'($urandom);
            d   = 8'($urandom_range(0, 3));
            bad = 1'b0;
`ifdef CHECKSUM_EN
            bad = ($urandom_range(0, 3) == 0);
`endif
            set_frame(c0, c1, d, bad ? (8'h01 << $urandom_range(0, 7)) : 8'h00);
            send_frame(4);
            if (bad) run_nak();
            else     run_exec(c0, c1, d, (d == 8'd0) ? 1 : int'(d) * DUR_TICKS, 8'h41);
            finish_resp();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
